// File: rtl/iob_div_subshift_signed_frac.sv
// Multi-cycle restoring subtract-shift divider with optional signed operands and
// FRAC_W fractional quotient bits: Q = (dividend << FRAC_W) / divisor, truncated toward zero.
module iob_div_subshift_signed_frac #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic                     cke_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     signed_i,
    input  logic [DATA_W-1:0]        dividend_i,
    input  logic [DATA_W-1:0]        divisor_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [DATA_W+FRAC_W-1:0] quotient_o,
    output logic [DATA_W-1:0]        remainder_o,
    output logic                     div_by_zero_o,
    output logic                     overflow_o
);
    localparam int QW    = DATA_W + FRAC_W;
    localparam int CNT_W = $clog2(QW);

    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  dd_q, dv_q, dvMag_q;
    logic               sgn_q, qneg_q, rneg_q;
    logic [QW-1:0]      sh_q;
    logic [DATA_W:0]    rem_q;
    logic               busy_q, done_q, dbz_q, ovf_q;
    logic [QW-1:0]      quot_q;
    logic [DATA_W-1:0]  remo_q;

    logic [DATA_W-1:0]  ddMag, dvMag, rFix;
    logic [DATA_W:0]    remShift, rem_d;
    logic [DATA_W+1:0]  diff;
    logic               qBit, ovfFix;
    logic [QW-1:0]      sh_d, qFix, qZero;
    logic [QW-1:0]      maxPos, minNeg;

    // sh_q starts as the shifted |dividend| and fills with quotient bits from the LSB end,
    // so after QW steps it holds the unsigned quotient magnitude.
    always_comb begin
        maxPos   = {1'b0, {(QW-1){1'b1}}};
        minNeg   = {1'b1, {(QW-1){1'b0}}};
        ddMag    = (sgn_q && dd_q[DATA_W-1]) ? -dd_q : dd_q;
        dvMag    = (sgn_q && dv_q[DATA_W-1]) ? -dv_q : dv_q;
        remShift = {rem_q[DATA_W-1:0], sh_q[QW-1]};
        diff     = {1'b0, remShift} - {2'b00, dvMag_q};
        qBit     = ~diff[DATA_W+1];
        rem_d    = qBit ? diff[DATA_W:0] : remShift;
        sh_d     = {sh_q[QW-2:0], qBit};
        ovfFix   = sgn_q & ~qneg_q & sh_q[QW-1];
        qFix     = sh_q;
        if (ovfFix) begin
            qFix = maxPos;
        end else if (qneg_q) begin
            qFix = -sh_q;
        end
        rFix     = rneg_q ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
        qZero    = '1;
        if (sgn_q) begin
            qZero = dd_q[DATA_W-1] ? minNeg : maxPos;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dd_q    <= '0;
            dv_q    <= '0;
            dvMag_q <= '0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            sh_q    <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                dd_q    <= '0;
                dv_q    <= '0;
                dvMag_q <= '0;
                sgn_q   <= 1'b0;
                qneg_q  <= 1'b0;
                rneg_q  <= 1'b0;
                sh_q    <= '0;
                rem_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                dbz_q   <= 1'b0;
                ovf_q   <= 1'b0;
                quot_q  <= '0;
                remo_q  <= '0;
            end else begin
                done_q <= 1'b0;
                case (state_q)
                    IDLE, DONE: begin
                        if (start_i) begin
                            state_q <= LOAD;
                            dd_q    <= dividend_i;
                            dv_q    <= divisor_i;
                            sgn_q   <= signed_i;
                            busy_q  <= 1'b1;
                            dbz_q   <= 1'b0;
                            ovf_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    LOAD: begin
                        dvMag_q <= dvMag;
                        qneg_q  <= sgn_q & (dd_q[DATA_W-1] ^ dv_q[DATA_W-1]);
                        rneg_q  <= sgn_q & dd_q[DATA_W-1];
                        sh_q    <= QW'(ddMag) << FRAC_W;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        if (dv_q == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                            quot_q  <= qZero;
                            remo_q  <= dd_q;
                        end else begin
                            state_q <= ITER;
                        end
                    end
                    ITER: begin
                        rem_q <= rem_d;
                        sh_q  <= sh_d;
                        if (cnt_q == CNT_W'(QW-1)) begin
                            state_q <= FIX;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    FIX: begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ovf_q   <= ovfFix;
                        quot_q  <= qFix;
                        remo_q  <= rFix;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = remo_q;
    assign div_by_zero_o = dbz_q;
    assign overflow_o    = ovf_q;
endmodule

// File: tb/tb_iob_div_subshift_signed_frac.sv
// Directed testbench for iob_div_subshift_signed_frac at DATA_W=8, FRAC_W=4 (QW=12).
module tb_iob_div_subshift_signed_frac;
    logic        clk, arstN, cke, rst, start, sgn;
    logic [7:0]  dividend, divisor;
    logic        busy, done, dbz, ovf;
    logic [11:0] quotient;
    logic [7:0]  remainder;
    int          nPass, nChecks;

    typedef struct {
        logic [7:0]  dd;
        logic [7:0]  dv;
        logic        sg;
        logic [11:0] q;
        logic [7:0]  r;
    } vec_t;

    iob_div_subshift_signed_frac #(.DATA_W(8), .FRAC_W(4)) dut (
        .clk_i(clk), .arst_n_i(arstN), .cke_i(cke), .rst_i(rst),
        .start_i(start), .signed_i(sgn), .dividend_i(dividend), .divisor_i(divisor),
        .busy_o(busy), .done_o(done), .quotient_o(quotient), .remainder_o(remainder),
        .div_by_zero_o(dbz), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge where done_o is seen (bounded).
    // Edges are counted after the accepting edge; cke_i is held low for the first ckeOff of them.
    task automatic runOp(input logic [7:0] dd, input logic [7:0] dv, input logic sg,
                         input int ckeOff, output int edges, output int busyCnt);
        dividend = dd; divisor = dv; sgn = sg; start = 1'b1;
        @(posedge clk);
        edges = 0; busyCnt = 0;
        @(negedge clk);
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom); sgn = ~sg;
        while (!done && edges < 200) begin
            if (busy) busyCnt++;
            cke = (edges < ckeOff) ? 1'b0 : 1'b1;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        cke = 1'b1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        nChecks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else nPass++;
        nChecks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else nPass++;
        nChecks++; if (quotient !== 12'h000) $display("[TB] FAIL reset_q: got %h expected 000", quotient); else nPass++;
        nChecks++; if (remainder !== 8'h00) $display("[TB] FAIL reset_r: got %h expected 00", remainder); else nPass++;
        nChecks++; if (dbz !== 1'b0) $display("[TB] FAIL reset_dbz: got %b expected 0", dbz); else nPass++;
        nChecks++; if (ovf !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); else nPass++;
        arstN = 1'b1;
    endtask

    task automatic test_unsigned_basic;
        int edges, busyCnt;
        @(negedge clk);
        runOp(8'd10, 8'd3, 1'b0, 0, edges, busyCnt);
        nChecks++; if (edges !== 14) $display("[TB] FAIL basic_latency: got %0d expected 14", edges); else nPass++;
        nChecks++; if (busyCnt !== 14) $display("[TB] FAIL basic_busy_cycles: got %0d expected 14", busyCnt); else nPass++;
        nChecks++; if (quotient !== 12'h035) $display("[TB] FAIL basic_q: got %h expected 035", quotient); else nPass++;
        nChecks++; if (remainder !== 8'h01) $display("[TB] FAIL basic_r: got %h expected 01", remainder); else nPass++;
        nChecks++; if ({dbz, ovf} !== 2'b00) $display("[TB] FAIL basic_flags: got %b expected 00", {dbz, ovf}); else nPass++;
        nChecks++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_in_done: got %b expected 0", busy); else nPass++;
        @(negedge clk);
        nChecks++; if (done !== 1'b0) $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); else nPass++;
        nChecks++; if (quotient !== 12'h035) $display("[TB] FAIL basic_q_hold: got %h expected 035", quotient); else nPass++;
    endtask

    task automatic test_arith;
        vec_t v[6];
        int edges, busyCnt;
        v[0] = '{8'hF6, 8'h03, 1'b1, 12'hFCB, 8'hFF};
        v[1] = '{8'h0A, 8'hFD, 1'b1, 12'hFCB, 8'h01};
        v[2] = '{8'h80, 8'h01, 1'b1, 12'h800, 8'h00};
        v[3] = '{8'hF9, 8'h02, 1'b1, 12'hFC8, 8'h00};
        v[4] = '{8'hFF, 8'h01, 1'b0, 12'hFF0, 8'h00};
        v[5] = '{8'hC8, 8'h07, 1'b0, 12'h1C9, 8'h01};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            runOp(v[i].dd, v[i].dv, v[i].sg, 0, edges, busyCnt);
            nChecks++; if (quotient !== v[i].q) $display("[TB] FAIL arith%0d_q: got %h expected %h", i, quotient, v[i].q); else nPass++;
            nChecks++; if (remainder !== v[i].r) $display("[TB] FAIL arith%0d_r: got %h expected %h", i, remainder, v[i].r); else nPass++;
            nChecks++; if ({dbz, ovf} !== 2'b00) $display("[TB] FAIL arith%0d_flags: got %b expected 00", i, {dbz, ovf}); else nPass++;
            nChecks++; if (edges !== 14) $display("[TB] FAIL arith%0d_latency: got %0d expected 14", i, edges); else nPass++;
        end
    endtask

    task automatic test_overflow;
        int edges, busyCnt;
        @(negedge clk);
        runOp(8'h80, 8'hFF, 1'b1, 0, edges, busyCnt);
        nChecks++; if (quotient !== 12'h7FF) $display("[TB] FAIL ovf_q: got %h expected 7ff", quotient); else nPass++;
        nChecks++; if (ovf !== 1'b1) $display("[TB] FAIL ovf_flag: got %b expected 1", ovf); else nPass++;
        nChecks++; if (dbz !== 1'b0) $display("[TB] FAIL ovf_dbz: got %b expected 0", dbz); else nPass++;
        nChecks++; if (remainder !== 8'h00) $display("[TB] FAIL ovf_r: got %h expected 00", remainder); else nPass++;
        nChecks++; if (edges !== 14) $display("[TB] FAIL ovf_latency: got %0d expected 14", edges); else nPass++;
    endtask

    task automatic test_div_by_zero;
        vec_t v[3];
        int edges, busyCnt;
        v[0] = '{8'h0A, 8'h00, 1'b0, 12'hFFF, 8'h0A};
        v[1] = '{8'h0A, 8'h00, 1'b1, 12'h7FF, 8'h0A};
        v[2] = '{8'hFF, 8'h00, 1'b1, 12'h800, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            runOp(v[i].dd, v[i].dv, v[i].sg, 0, edges, busyCnt);
            nChecks++; if (quotient !== v[i].q) $display("[TB] FAIL dbz%0d_q: got %h expected %h", i, quotient, v[i].q); else nPass++;
            nChecks++; if (remainder !== v[i].r) $display("[TB] FAIL dbz%0d_r: got %h expected %h", i, remainder, v[i].r); else nPass++;
            nChecks++; if ({dbz, ovf} !== 2'b10) $display("[TB] FAIL dbz%0d_flags: got %b expected 10", i, {dbz, ovf}); else nPass++;
            nChecks++; if (edges !== 1) $display("[TB] FAIL dbz%0d_latency: got %0d expected 1", i, edges); else nPass++;
        end
    endtask

    task automatic test_abort;
        int edges, busyCnt;
        @(negedge clk);
        dividend = 8'd10; divisor = 8'd3; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        arstN = 1'b0;
        #1;
        nChecks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else nPass++;
        nChecks++; if (quotient !== 12'h000) $display("[TB] FAIL abort_q: got %h expected 000", quotient); else nPass++;
        nChecks++; if ({done, dbz, ovf, remainder} !== 11'h000) $display("[TB] FAIL abort_rest: got %h expected 000", {done, dbz, ovf, remainder}); else nPass++;
        @(negedge clk);
        arstN = 1'b1;
        @(negedge clk);
        runOp(8'd10, 8'd3, 1'b0, 0, edges, busyCnt);
        nChecks++; if (quotient !== 12'h035) $display("[TB] FAIL abort_next_q: got %h expected 035", quotient); else nPass++;
        nChecks++; if (edges !== 14) $display("[TB] FAIL abort_next_latency: got %0d expected 14", edges); else nPass++;
    endtask

    task automatic test_back_to_back;
        int edges, busyCnt;
        @(negedge clk);
        runOp(8'h80, 8'hFF, 1'b1, 0, edges, busyCnt);
        nChecks++; if (ovf !== 1'b1) $display("[TB] FAIL b2b_first_ovf: got %b expected 1", ovf); else nPass++;
        runOp(8'hC8, 8'h07, 1'b0, 0, edges, busyCnt);
        nChecks++; if (edges !== 14) $display("[TB] FAIL b2b_latency: got %0d expected 14", edges); else nPass++;
        nChecks++; if (quotient !== 12'h1C9) $display("[TB] FAIL b2b_q: got %h expected 1c9", quotient); else nPass++;
        nChecks++; if (ovf !== 1'b0) $display("[TB] FAIL b2b_ovf: got %b expected 0", ovf); else nPass++;
    endtask

    task automatic test_cke;
        int edges, busyCnt;
        @(negedge clk);
        runOp(8'd10, 8'd3, 1'b0, 5, edges, busyCnt);
        nChecks++; if (edges !== 19) $display("[TB] FAIL cke_latency: got %0d expected 19", edges); else nPass++;
        nChecks++; if (quotient !== 12'h035) $display("[TB] FAIL cke_q: got %h expected 035", quotient); else nPass++;
    endtask

    task automatic test_sync_clear;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nChecks++; if (quotient !== 12'h000) $display("[TB] FAIL clear_q: got %h expected 000", quotient); else nPass++;
        nChecks++; if (remainder !== 8'h00) $display("[TB] FAIL clear_r: got %h expected 00", remainder); else nPass++;
    endtask

    initial begin
        clk = 1'b0; arstN = 1'b0; cke = 1'b1; rst = 1'b0; start = 1'b0;
        sgn = 1'b0; dividend = '0; divisor = '0;
        nPass = 0; nChecks = 0;
        test_reset;
        test_unsigned_basic;
        test_arith;
        test_overflow;
        test_div_by_zero;
        test_abort;
        test_back_to_back;
        test_cke;
        test_sync_clear;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
